bau_req_queue: RTL
==================

Name: bau_req_queue

Overview:
- Requester-side front end of the bus arbitration unit (bau).
- Buffers bus requests {sender, dest} in order and presents the head entry to the bau on sender/dest/req_ready.
- Pops the head entry when the bau asserts pull.
- Sits between the bus-using units (IE, IO, DE, DO, B0-B3, DMA) and the bau.

Parameters:
- DEPTH, 8, number of request entries; must be a power of 2, minimum 2.
- ID_W, 4, width of the sender and dest unit IDs.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous active-low reset.
- enq_valid  input  1  a unit presents a request this cycle.
- enq_sender  input  ID_W  requesting unit ID.
- enq_dest  input  ID_W  destination unit ID.
- enq_ready  output  1  queue can accept; the request is taken when enq_valid and enq_ready are both 1 at the clock edge.
- flush  input  1  synchronous discard of all entries.
- pull  input  1  from bau; head entry consumed at this edge.
- req_ready  output  1  head entry valid (queue not empty); to bau.
- sender  output  ID_W  head entry sender; 0 when empty.
- dest  output  ID_W  head entry dest; 0 when empty.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf_err  output  1  sticky: enq_valid asserted while full.
- unf_err  output  1  sticky: pull asserted while empty.

Behaviour:
- Reset (clr=0, async):
  - rd_ptr = wr_ptr = 0, count = 0; ovf_err = unf_err = 0.
  - Outputs: req_ready = 0, sender = dest = 0, empty = 1, full = 0, enq_ready = 1.
  - Storage contents don't-care.
  - Reset mid-operation discards all entries immediately; there is no partial pop.
- enq_ready = !full. No bypass: a pull in the same cycle does not free a slot for an enqueue while full.
- Enqueue (enq_valid & enq_ready): write {enq_sender, enq_dest} at wr_ptr; wr_ptr += 1, wrapping DEPTH-1 -> 0.
- Pop (pull & !empty): rd_ptr += 1 with wrap.
- count update per cycle:
  - +1 on enqueue only.
  - -1 on pop only.
  - unchanged on both or neither.
- Latency: an entry enqueued at edge N appears on sender/dest with req_ready = 1 after edge N, i.e. in the cycle following the write.
- Head outputs:
  - Combinational from storage[rd_ptr], gated to 0 when empty.
  - Next entry is visible in the cycle after the pull edge.
- pull while empty: ignored (no pointer or count change); sets unf_err.
- enq_valid while full: request dropped (no write); sets ovf_err.
- Error flags: ovf_err and unf_err clear only on reset.
- flush (synchronous, highest priority):
  - rd_ptr = wr_ptr = 0, count = 0.
  - Same-cycle enq and pull are ignored.
  - Error flags are unaffected.
- Order is strict FIFO; no reordering by sender or dest.
- IDs are opaque ID_W-bit values; no range checking.
- Simultaneous enqueue and pop at count = 1: head advances to the new entry; req_ready stays 1.

Decomposition:
- Shared package bus_pkg:
  - ID_W.
  - Unit ID localparams: UID_IE=0, UID_IO=1, UID_DE=2, UID_DO=3, UID_B0=4, UID_B1=5, UID_B2=6, UID_B3=7, UID_DMA=8.
  - typedef bus_req_t = packed {sender, dest}.
- One sub-module, bau_req_mem:
  - DEPTH x 2*ID_W register array.
  - Synchronous write port, asynchronous read port.
  - No reset on the array.
- Pointers, count, flags and gating live in bau_req_queue.

Test Plan:
- Reset release → outputs idle:
  - Stimulus: clr low for 1 cycle, then high.
  - Response: req_ready=0, empty=1, count=0, sender=dest=0, enq_ready=1.
- Single enqueue, then pull:
  - Stimulus: enqueue {sender=0, dest=0xC}.
  - Next cycle: req_ready=1, sender=0, dest=0xC, count=1.
  - Pull one cycle: req_ready=0 on the following cycle, count=0.
- Fill and wrap:
  - Stimulus: enqueue 8 entries with sender=i, dest=0xF-i, i=0..7.
  - Response: full=1, enq_ready=0.
  - 9th enqueue: dropped, ovf_err=1.
  - Pull 3, enqueue 3 more (i=8..10): pulls in FIFO order yield sender 3,4,...,10.
- Simultaneous enqueue and pull:
  - Stimulus: count=1 (head {0xC,0xB}); enqueue {0x8,0x0} while pull=1.
  - Response: count stays 1; head becomes {0x8,0x0} next cycle.
- Underflow:
  - Stimulus: pull=1 while empty.
  - Response: unf_err=1; count stays 0; a subsequent enqueue works normally.
- Flush and async reset:
  - Stimulus: 5 entries queued; flush=1 together with enq_valid=1.
  - Response: count=0, empty=1, the enqueue is ignored.
  - Then: refill 2 entries, drop clr mid-cycle.
  - Response: outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: unit IDs and the request word carried through the bau.
package bus_pkg;

    localparam int ID_W = 4;

    localparam logic [ID_W-1:0] UID_IE  = 4'd0;
    localparam logic [ID_W-1:0] UID_IO  = 4'd1;
    localparam logic [ID_W-1:0] UID_DE  = 4'd2;
    localparam logic [ID_W-1:0] UID_DO  = 4'd3;
    localparam logic [ID_W-1:0] UID_B0  = 4'd4;
    localparam logic [ID_W-1:0] UID_B1  = 4'd5;
    localparam logic [ID_W-1:0] UID_B2  = 4'd6;
    localparam logic [ID_W-1:0] UID_B3  = 4'd7;
    localparam logic [ID_W-1:0] UID_DMA = 4'd8;

    typedef struct packed {
        logic [ID_W-1:0] sender;
        logic [ID_W-1:0] dest;
    } bus_req_t;

endpackage

// File: rtl/bau_req_mem.sv
// Request storage for the bau queue: register array, synchronous write,
// asynchronous read. The array is not reset; validity is tracked by the
// pointers and count in the parent.
module bau_req_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed slot when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed slot
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/bau_req_queue.sv
// Requester-side FIFO in front of the bus arbitration unit. Requests
// {sender, dest} are buffered in order; the head entry is presented to the
// bau and popped when it asserts pull. Flush discards everything; overflow
// and underflow attempts are recorded in sticky flags cleared only by reset.
module bau_req_queue
    import bus_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ID_W  = bus_pkg::ID_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     enq_valid,
    input  logic [ID_W-1:0]          enq_sender,
    input  logic [ID_W-1:0]          enq_dest,
    output logic                     enq_ready,
    input  logic                     flush,
    input  logic                     pull,
    output logic                     req_ready,
    output logic [ID_W-1:0]          sender,
    output logic [ID_W-1:0]          dest,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf_err,
    output logic                     unf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int W     = 2 * ID_W;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_err_q, ovf_err_d;
    logic             unf_err_q, unf_err_d;

    logic             full_w;
    logic             empty_w;
    logic             do_enq;
    logic             do_pop;
    logic [W-1:0]     head_w;

    // Occupancy status and qualified enqueue/pop strobes; flush overrides both
    always_comb begin
        full_w  = (count_q == CNT_W'(DEPTH));
        empty_w = (count_q == '0);
        // No bypass: a same-cycle pull does not make room while full
        do_enq  = enq_valid && !full_w && !flush;
        do_pop  = pull && !empty_w && !flush;
    end

    // Next pointers, count and sticky error flags
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ovf_err_d = ovf_err_q || (enq_valid && full_w);
        unf_err_d = unf_err_q || (pull && empty_w);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_enq && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_err_q <= 1'b0;
            unf_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_err_q <= ovf_err_d;
            unf_err_q <= unf_err_d;
        end
    end

    bau_req_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we    (do_enq),
        .waddr (wr_ptr_q),
        .wdata ({enq_sender, enq_dest}),
        .raddr (rd_ptr_q),
        .rdata (head_w)
    );

    // Head presentation, gated to zero when nothing is stored
    always_comb begin
        enq_ready = !full_w;
        req_ready = !empty_w;
        sender    = empty_w ? '0 : head_w[W-1:ID_W];
        dest      = empty_w ? '0 : head_w[ID_W-1:0];
        count     = count_q;
        full      = full_w;
        empty     = empty_w;
        ovf_err   = ovf_err_q;
        unf_err   = unf_err_q;
    end

endmodule
